// File: rtl/mono_rx_fifo_arbiter.sv
// mono_rx_fifo_arbiter
//   Merges the 32-bit word streams of N_SRC first-word-fall-through receiver
//   FIFOs into one FIFO-style output stream. Sources are served round-robin.
//   A grant is held for a whole hit group of GROUP_LEN words, so groups are
//   never interleaved. A group whose source stays empty for TIMEOUT cycles
//   (with room downstream) is abandoned and counted in ABORT_CNT.
//
// Ports
//   BUS_CLK    clock
//   RST        synchronous reset, active-high
//   SRC_EN     per-source enable, looked at only while arbitrating
//   SRC_EMPTY  per-source FIFO empty flags
//   SRC_READ   per-source pop strobes (combinational, at most one bit high)
//   SRC_DATA   per-source head words, source i at [32*i+31:32*i]
//   OUT_READ   downstream pop
//   OUT_EMPTY  output register holds no valid word
//   OUT_DATA   output word
//   GRANT_ID   index of the granted source (debug)
//   BUSY       high while a group is being transferred
//   ABORT_CNT  saturating count of groups truncated by timeout
module mono_rx_fifo_arbiter #(
  parameter int N_SRC     = 4,
  parameter int GROUP_LEN = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [N_SRC-1:0]     SRC_EN,
  input  logic [N_SRC-1:0]     SRC_EMPTY,
  output logic [N_SRC-1:0]     SRC_READ,
  input  logic [32*N_SRC-1:0]  SRC_DATA,
  input  logic                 OUT_READ,
  output logic                 OUT_EMPTY,
  output logic [31:0]          OUT_DATA,
  output logic [3:0]           GRANT_ID,
  output logic                 BUSY,
  output logic [7:0]           ABORT_CNT
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {ARB, XFER} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [3:0]         word_cnt_q, word_cnt_d;
  logic [15:0]        idle_cnt_q, idle_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_data_q, out_data_d;
  logic [7:0]         abort_cnt_q, abort_cnt_d;

  logic [N_SRC-1:0]   req;
  logic               load_ok;
  logic               pop;
  logic [31:0]        grant_word;
  logic [PTR_W-1:0]   grant_next;

  // First requesting source at or above start, wrapping at N_SRC.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [N_SRC-1:0] r,
                                                input logic [PTR_W-1:0] start);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] pick;
    logic             found;
    idx   = start;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == PTR_W'(N_SRC - 1)) ? '0 : idx + PTR_W'(1);
    end
    return pick;
  endfunction

  assign req        = SRC_EN & ~SRC_EMPTY;
  assign load_ok    = !out_valid_q || OUT_READ;
  assign grant_word = SRC_DATA[{grant_q, 5'd0} +: 32];
  assign pop        = (state_q == XFER) && load_ok && !SRC_EMPTY[grant_q];
  assign grant_next = (grant_q == PTR_W'(N_SRC - 1)) ? '0 : grant_q + PTR_W'(1);

  // NOTE: every signal written here gets its default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    word_cnt_d  = word_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    abort_cnt_d = abort_cnt_q;
    SRC_READ    = '0;

    // Output register: a pop refills it (even when drained in the same
    // cycle); otherwise a downstream read empties it.
    if (pop) begin
      SRC_READ[grant_q] = 1'b1;
      out_valid_d       = 1'b1;
      out_data_d        = grant_word;
    end else if (OUT_READ) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB: begin
        if (|req) begin
          grant_d    = rr_pick(req, rr_ptr_q);
          word_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          word_cnt_d = word_cnt_q + 4'd1;
          idle_cnt_d = '0;
          if (word_cnt_q == 4'(GROUP_LEN - 1)) begin
            rr_ptr_d = grant_next;
            state_d  = ARB;
          end
        end else if (load_ok) begin
          // Room downstream but no pop: the granted source is empty. A
          // downstream stall never lands here, so it cannot cause an abort.
          if (idle_cnt_q == 16'(TIMEOUT - 1)) begin
            if (abort_cnt_q != 8'hFF) begin
              abort_cnt_d = abort_cnt_q + 8'd1;
            end
            rr_ptr_d = grant_next;
            state_d  = ARB;
          end else begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q     <= ARB;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      word_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      word_cnt_q  <= word_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign OUT_EMPTY = !out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign GRANT_ID  = 4'(grant_q);
  assign BUSY      = (state_q == XFER);
  assign ABORT_CNT = abort_cnt_q;

endmodule
